// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: stall/flush control, $zero write suppression, saturating bubble counter.
// Define EXMEM_FWD_EN to add the EX->EX forwarding comparators and their ports.
module ex_mem_pipe_reg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_rt_data,
    input  logic [RW-1:0] ex_write_reg,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_mem_to_reg,
`ifdef EXMEM_FWD_EN
    input  logic [RW-1:0] id_ex_rs,
    input  logic [RW-1:0] id_ex_rt,
    output logic          fwd_a_hit,
    output logic          fwd_b_hit,
`endif
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_result,
    output logic [DW-1:0] mem_rt_data,
    output logic [RW-1:0] mem_write_reg,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic          mem_mem_to_reg,
    output logic [CW-1:0] bubble_count
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] rt_data;
        logic [RW-1:0] write_reg;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } stage_t;

    stage_t        stage_d, stage_q;
    logic [CW-1:0] bubble_d, bubble_q;
    logic [CW-1:0] bubble_inc;

    // Counter sticks at all-ones rather than wrapping.
    assign bubble_inc = (bubble_q == {CW{1'b1}}) ? bubble_q : bubble_q + CW'(1);

    always_comb begin
        stage_d  = stage_q;
        bubble_d = bubble_q;
        if (flush) begin
            stage_d  = '0;
            bubble_d = bubble_inc;
        end else if (!stall) begin
            stage_d.valid      = ex_valid;
            stage_d.alu_result = ex_alu_result;
            stage_d.rt_data    = ex_rt_data;
            stage_d.write_reg  = ex_write_reg;
            // Writes to $zero are dropped here so MEM/WB and forwarding never see them.
            stage_d.reg_write  = ex_reg_write & ex_valid & (ex_write_reg != '0);
            stage_d.mem_read   = ex_mem_read & ex_valid;
            stage_d.mem_write  = ex_mem_write & ex_valid;
            stage_d.mem_to_reg = ex_mem_to_reg & ex_valid;
            if (!ex_valid)
                bubble_d = bubble_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q  <= '0;
            bubble_q <= '0;
        end else begin
            stage_q  <= stage_d;
            bubble_q <= bubble_d;
        end
    end

    assign mem_valid      = stage_q.valid;
    assign mem_alu_result = stage_q.alu_result;
    assign mem_rt_data    = stage_q.rt_data;
    assign mem_write_reg  = stage_q.write_reg;
    assign mem_reg_write  = stage_q.reg_write;
    assign mem_mem_read   = stage_q.mem_read;
    assign mem_mem_write  = stage_q.mem_write;
    assign mem_mem_to_reg = stage_q.mem_to_reg;
    assign bubble_count   = bubble_q;

`ifdef EXMEM_FWD_EN
    // Qualified reg_write already excludes $zero destinations.
    assign fwd_a_hit = stage_q.reg_write & (stage_q.write_reg == id_ex_rs);
    assign fwd_b_hit = stage_q.reg_write & (stage_q.write_reg == id_ex_rt);
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: expected stage contents are queued at drive time
// and popped/compared one cycle later.
module tb_ex_mem_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, stall, flush, ex_valid;
    logic [DW-1:0] ex_alu_result, ex_rt_data;
    logic [RW-1:0] ex_write_reg;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          mem_valid;
    logic [DW-1:0] mem_alu_result, mem_rt_data;
    logic [RW-1:0] mem_write_reg;
    logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic [CW-1:0] bubble_count;
`ifdef EXMEM_FWD_EN
    logic [RW-1:0] id_ex_rs, id_ex_rt;
    logic          fwd_a_hit, fwd_b_hit;
`endif

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_rt_data(ex_rt_data), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg),
`ifdef EXMEM_FWD_EN
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
`endif
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_rt_data(mem_rt_data),
        .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg), .bubble_count(bubble_count)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] alu, rt;
        logic [RW-1:0] wreg;
        logic          rw, mr, mw, m2r;
        logic [CW-1:0] bub;
    } exp_t;

    exp_t mdl;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One clock: drive inputs at negedge, queue expectation, compare after the posedge.
    task automatic step(input bit rst, input bit st, input bit fl, input bit v,
                        input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wr,
                        input bit rw, input bit mr, input bit mw, input bit m2r);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = st; flush = fl; ex_valid = v;
        ex_alu_result = alu; ex_rt_data = rt; ex_write_reg = wr;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
        if (rst) begin
            mdl = '{valid: 0, alu: 0, rt: 0, wreg: 0, rw: 0, mr: 0, mw: 0, m2r: 0, bub: 0};
        end else if (fl) begin
            mdl = '{valid: 0, alu: 0, rt: 0, wreg: 0, rw: 0, mr: 0, mw: 0, m2r: 0,
                    bub: sat_inc(mdl.bub)};
        end else if (!st) begin
            mdl.valid = v; mdl.alu = alu; mdl.rt = rt; mdl.wreg = wr;
            mdl.rw = rw && v && (wr != 0);
            mdl.mr = mr && v; mdl.mw = mw && v; mdl.m2r = m2r && v;
            if (!v) mdl.bub = sat_inc(mdl.bub);
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sb.pop_front();
            check("mem_valid",      32'(mem_valid),      32'(e.valid));
            check("mem_alu_result", mem_alu_result,      e.alu);
            check("mem_rt_data",    mem_rt_data,         e.rt);
            check("mem_write_reg",  32'(mem_write_reg),  32'(e.wreg));
            check("mem_reg_write",  32'(mem_reg_write),  32'(e.rw));
            check("mem_mem_read",   32'(mem_mem_read),   32'(e.mr));
            check("mem_mem_write",  32'(mem_mem_write),  32'(e.mw));
            check("mem_mem_to_reg", 32'(mem_mem_to_reg), 32'(e.m2r));
            check("bubble_count",   32'(bubble_count),   32'(e.bub));
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; ex_valid = 0;
        ex_alu_result = 0; ex_rt_data = 0; ex_write_reg = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        mdl = '{valid: 0, alu: 0, rt: 0, wreg: 0, rw: 0, mr: 0, mw: 0, m2r: 0, bub: 0};
`ifdef EXMEM_FWD_EN
        id_ex_rs = 0; id_ex_rt = 0;
`endif
        // Reset state, with stall/flush also high to show they are ignored.
        step(1, 1, 1, 1, 32'hDEAD, 32'hBEEF, 5'd3, 1, 1, 1, 1);
        check("reset bubble_count", 32'(bubble_count), 32'd0);

        // Basic load.
        step(0, 0, 0, 1, 32'h0000_00A5, 32'h11, 5'd8, 1, 0, 0, 0);
        check("A5 alu", mem_alu_result, 32'hA5);
        check("A5 reg_write", 32'(mem_reg_write), 32'd1);

`ifdef EXMEM_FWD_EN
        step(0, 0, 0, 1, 32'h9, 32'h0, 5'd9, 1, 0, 0, 0);
        id_ex_rs = 9; id_ex_rt = 9; #1;
        check("fwd_a hit", 32'(fwd_a_hit), 32'd1);
        check("fwd_b hit", 32'(fwd_b_hit), 32'd1);
        id_ex_rt = 10; #1;
        check("fwd_b miss", 32'(fwd_b_hit), 32'd0);
        step(0, 0, 1, 1, 32'h9, 32'h0, 5'd9, 1, 0, 0, 0);
        id_ex_rt = 9; #1;
        check("fwd_a after flush", 32'(fwd_a_hit), 32'd0);
        check("fwd_b after flush", 32'(fwd_b_hit), 32'd0);
`endif

        // $zero destination suppresses reg_write but keeps valid.
        step(0, 0, 0, 1, 32'h55, 32'h66, 5'd0, 1, 0, 0, 1);
        check("zero dest reg_write", 32'(mem_reg_write), 32'd0);
        check("zero dest valid", 32'(mem_valid), 32'd1);

        // Store with both read and write set: passed through qualified.
        step(0, 0, 0, 1, 32'h100, 32'hCAFE_F00D, 5'd4, 0, 1, 1, 0);
        // Invalid load is a bubble and kills all control bits.
        step(0, 0, 0, 0, 32'h200, 32'h300, 5'd7, 1, 1, 1, 1);
        check("invalid bubble", 32'(bubble_count), 32'd1);

        // Stall holds for three cycles with changing inputs, then fresh inputs load.
        step(0, 0, 0, 1, 32'h1234, 32'h5678, 5'd12, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, i[0], 32'hF000 + 32'(i), 32'h0, 5'(20 + i), 1, 0, 1, 0);
        check("stall hold alu", mem_alu_result, 32'h1234);
        step(0, 0, 0, 1, 32'h4321, 32'h8765, 5'd13, 1, 0, 0, 0);
        check("post-stall load", mem_alu_result, 32'h4321);

        // Flush beats stall.
        step(0, 1, 1, 1, 32'h77, 32'h88, 5'd5, 1, 1, 1, 1);
        check("flush over stall valid", 32'(mem_valid), 32'd0);
        check("flush over stall bubble", 32'(bubble_count), 32'd2);

        // Saturation: 2^CW+3 consecutive flushes.
        for (int i = 0; i < (1 << CW) + 3; i++)
            step(0, 0, 1, 1, 32'(i), 32'(i), 5'd1, 1, 1, 1, 1);
        check("saturated", 32'(bubble_count), 32'h0000_FFFF);

        // Reset mid-flush clears the counter.
        step(1, 1, 1, 1, 32'h1, 32'h2, 5'd3, 1, 1, 1, 1);
        check("reset clears bubble", 32'(bubble_count), 32'd0);
        step(0, 0, 0, 1, 32'hABCD, 32'h1, 5'd31, 1, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
